qspi_stream_ctrl: RTL and testbench
===================================

# qspi_stream_ctrl

Sequencer and prefetch buffer between the QSPI flash reader and the video instruction decoder. It holds the reader in reset until streaming is enabled and paces the reader through its `shift_data` handshake. It captures each 18-bit instruction into a small FIFO and serves the FIFO to the decoder with valid/ready. When an end-of-video marker arrives, it restarts the reader from the beginning of flash.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `RST_CYCLES`, 4: cycles that `qspi_rst_n` is held low on a restart; ≥ 1.
- `END_WORD`, 18'h3FFFF: instruction value marking end of video; never forwarded to the decoder.
- `clk` in 1: system clock; the same clock drives the QSPI reader.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: level; high = stream video, low = stop and flush.
- `qspi_rst_n` out 1: registered reset to the QSPI reader (its reset is synchronous, active-low).
- `qspi_shift` out 1: to the reader's `shift_data`; permission to fetch the next word.
- `qspi_instr` in 18: reader instruction word.
- `qspi_valid` in 1: reader valid flag.
- `instr_out` out 18: FIFO head.
- `instr_valid` out 1: FIFO not empty.
- `instr_ready` in 1: decoder accepts head when `instr_valid & instr_ready`.
- `frame_done` out 1: one-cycle pulse when `END_WORD` is captured.
- `overflow` out 1: sticky; a word was captured while the FIFO was full.

## Operation
- States:
  - OFF: `qspi_rst_n`=0.
  - STREAM: `qspi_rst_n`=1.
  - RESTART: `qspi_rst_n`=0, with a restart counter running.
- Transitions:
  - OFF→STREAM when `enable`=1.
  - STREAM→RESTART when a captured word equals `END_WORD`.
  - RESTART→STREAM when the counter reaches `RST_CYCLES` and the FIFO is empty.
  - Any state→OFF when `enable`=0. This transition flushes the FIFO and clears the restart counter. `overflow` is not cleared.
- Capture:
  - `valid_q` registers `qspi_valid`.
  - A word is captured when `qspi_valid & ~valid_q` and state is STREAM.
  - The reader can hold valid high for several cycles for one word. Only the rising edge counts.
  - `valid_q` is forced to 0 in OFF and RESTART.
- On capture of a word ≠ `END_WORD`: push it. If the FIFO is full, drop the word and set `overflow`.
- On capture of `END_WORD`: no push; pulse `frame_done`; enter RESTART. Words already in the FIFO stay available to the decoder.
- `qspi_shift` = (state == STREAM) & (DEPTH − count ≥ 2). It is combinational from registered state and count.
  - This guarantees a free slot for the word in flight. Words are ≥ 6 cycles apart.
- FIFO:
  - Show-ahead.
  - Count width is clog2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Pop of an empty FIFO is ignored.
  - A push into an empty FIFO is visible on `instr_out` the next cycle.
- Words captured in OFF or RESTART are discarded silently; they do not set `overflow`.

## Timing
- Reset values:
  - State OFF.
  - `qspi_rst_n`=0, `qspi_shift`=0.
  - `instr_valid`=0, `instr_out`=0.
  - `frame_done`=0, `overflow`=0.
  - Count and pointers 0; `valid_q`=0.
- Enable to reader: `enable` high at edge t gives `qspi_rst_n`=1 from cycle t+1.
- Capture latency: a rising edge of `qspi_valid` sampled at edge t (FIFO previously empty) gives `instr_valid`=1 and `instr_out`=word in cycle t+1.
- End marker: `END_WORD` captured at edge t gives the following, all from cycle t+1:
  - `frame_done`=1 for that cycle only.
  - `qspi_rst_n`=0.
  - `qspi_shift`=0.
- Restart length: `qspi_rst_n` stays low for at least `RST_CYCLES` cycles. It stays low longer until the decoder drains the FIFO, then rises on the following edge.
- `enable` low at edge t: cycle t+1 has `instr_valid`=0 and `qspi_rst_n`=0. A pop requested in cycle t is still honoured.
- Simultaneous events in one cycle:
  - `END_WORD` capture together with `enable`=0: OFF wins. `frame_done` still pulses.
  - Pop together with push into a full FIFO: the push succeeds and `overflow` is not set.
- Asynchronous reset mid-stream returns everything to reset values immediately. Reset release is synchronised by the clock domain owner.

## Test plan
- Basic stream: `enable`=1 with a reader model emitting 18'h00001..18'h00005 and the decoder always ready. Required: `instr_out` shows the five words in order, each one cycle after its valid edge; `qspi_shift` stays 1.
- Back-pressure: decoder not ready with `DEPTH`=4. Required: `qspi_shift` drops once count = 3; the reader holds valid high; no duplicate word is captured; `overflow` stays 0. After `instr_ready`=1, `qspi_shift` returns and the sequence continues with no gaps.
- End marker: words 18'h00010, 18'h00011, then 18'h3FFFF with the decoder stalled for 10 cycles. Required: `frame_done` pulses once; `qspi_rst_n` stays low for 10+ cycles until the FIFO drains, then goes high; 18'h3FFFF never appears on `instr_out`.
- Disable mid-stream: FIFO holding 2 words, then `enable`=0 for 1 cycle. Required: `instr_valid`=0 and `qspi_rst_n`=0 next cycle; after `enable` returns, the first word out is a fresh read.
- Forced overflow: the reader model ignores `qspi_shift` and pushes 5 words into `DEPTH`=4 with no pops. Required: the first 4 words are retained and `overflow`=1 sticky.
- Async reset asserted mid-capture, between clock edges. Required: all outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/qspi_stream_ctrl.sv
// qspi_stream_ctrl: sequences the QSPI flash reader (reset / shift pacing),
// buffers captured 18-bit instructions in a show-ahead FIFO for the decoder,
// and restarts the reader from the start of flash on the end-of-video marker.
module qspi_stream_ctrl #(
    parameter int          DEPTH      = 4,
    parameter int          RST_CYCLES = 4,
    parameter logic [17:0] END_WORD   = 18'h3FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        qspi_rst_n,
    output logic        qspi_shift,
    input  logic [17:0] qspi_instr,
    input  logic        qspi_valid,
    output logic [17:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        frame_done,
    output logic        overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int RCW = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_STREAM  = 2'd1,
        S_RESTART = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_qspi_rst_n;
    logic            r_valid_q;
    logic [RCW-1:0]  r_rst_cnt;
    logic            r_frame_done;
    logic            r_overflow;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [17:0]     r_mem [DEPTH];

    logic            w_capture;
    logic            w_is_end;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [RCW-1:0]  w_rst_cnt_nxt;

    // Only a rising edge of the reader's valid in STREAM is a new word.
    assign w_capture = qspi_valid & ~r_valid_q & (r_state == S_STREAM);
    assign w_is_end  = (qspi_instr == END_WORD);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = instr_ready & (r_count != '0);
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_push    = w_capture & ~w_is_end & (~w_full | w_pop);
    assign w_drop    = w_capture & ~w_is_end & w_full & ~w_pop;

    // Counter saturates so the restart can wait indefinitely for the drain.
    assign w_rst_cnt_nxt = (r_rst_cnt == RCW'(RST_CYCLES)) ? r_rst_cnt : r_rst_cnt + 1'b1;

    // Keep one slot free for the word already in flight from the reader.
    assign qspi_shift  = (r_state == S_STREAM) && (r_count <= CW'(DEPTH - 2));
    assign qspi_rst_n  = r_qspi_rst_n;
    assign instr_valid = (r_count != '0);
    assign instr_out   = instr_valid ? r_mem[r_rd_ptr] : '0;
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;

    // Sequencer FSM with registered reader reset, end-marker pulse and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_OFF;
            r_qspi_rst_n <= 1'b0;
            r_valid_q    <= 1'b0;
            r_rst_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_capture & w_is_end;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (!enable) begin
                r_state      <= S_OFF;
                r_qspi_rst_n <= 1'b0;
                r_rst_cnt    <= '0;
                r_valid_q    <= 1'b0;
            end else begin
                case (r_state)
                    S_OFF: begin
                        r_state      <= S_STREAM;
                        r_qspi_rst_n <= 1'b1;
                        r_valid_q    <= 1'b0;
                    end
                    S_STREAM: begin
                        r_valid_q <= qspi_valid;
                        if (w_capture && w_is_end) begin
                            r_state      <= S_RESTART;
                            r_qspi_rst_n <= 1'b0;
                            r_rst_cnt    <= '0;
                            r_valid_q    <= 1'b0;
                        end
                    end
                    S_RESTART: begin
                        r_valid_q <= 1'b0;
                        r_rst_cnt <= w_rst_cnt_nxt;
                        if ((w_rst_cnt_nxt == RCW'(RST_CYCLES)) && (r_count == '0)) begin
                            r_state      <= S_STREAM;
                            r_qspi_rst_n <= 1'b1;
                        end
                    end
                    default: begin
                        r_state      <= S_OFF;
                        r_qspi_rst_n <= 1'b0;
                        r_valid_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // FIFO occupancy and pointers; disabling flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (!enable) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= qspi_instr;
        end
    end

endmodule

// File: tb/tb_qspi_stream_ctrl.sv
// Testbench for qspi_stream_ctrl: directed reader/decoder stimulus with a
// scoreboard queue of expected decoder words checked by a separate monitor.
module tb_qspi_stream_ctrl;

    localparam logic [17:0] END_W = 18'h3FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        qspi_rst_n;
    logic        qspi_shift;
    logic [17:0] qspi_instr;
    logic        qspi_valid;
    logic [17:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        frame_done;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    logic [17:0] sb[$];

    qspi_stream_ctrl #(.DEPTH(4), .RST_CYCLES(4), .END_WORD(END_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .qspi_rst_n  (qspi_rst_n),
        .qspi_shift  (qspi_shift),
        .qspi_instr  (qspi_instr),
        .qspi_valid  (qspi_valid),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted decoder word must match the scoreboard head.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", {14'd0, instr_out}, 32'h0);
                checks--;
                if (instr_out === 18'h0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", instr_out);
                end
                checks++;
            end else begin
                chk("sb_word", {14'd0, instr_out}, {14'd0, sb.pop_front()});
            end
        end
    end

    // Present one word on a reader valid rising edge; returns in the cycle after capture.
    task automatic issue(input logic [17:0] w, input bit wait_shift, input bit chk_head);
        int n = 0;
        if (wait_shift) begin
            while (!qspi_shift && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("shift_wait", {31'd0, qspi_shift}, 32'd1);
        end
        qspi_instr = w;
        qspi_valid = 1'b1;
        @(negedge clk);
        if (chk_head) begin
            chk("latency_valid", {31'd0, instr_valid}, 32'd1);
            chk("latency_word", {14'd0, instr_out}, {14'd0, w});
        end
    endtask

    task automatic finish_word(input int hold);
        repeat (hold) @(negedge clk);
        qspi_valid = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        instr_ready = 1'b1;
        while (instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_done", {31'd0, instr_valid}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int low;
        int n;
        rst_n       = 1'b0;
        enable      = 1'b0;
        qspi_instr  = '0;
        qspi_valid  = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_qspi_rst_n", {31'd0, qspi_rst_n}, 32'd0);
        chk("rst_shift", {31'd0, qspi_shift}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr_out", {14'd0, instr_out}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("off_qspi_rst_n", {31'd0, qspi_rst_n}, 32'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("enable_rst_n", {31'd0, qspi_rst_n}, 32'd1);
        chk("enable_shift", {31'd0, qspi_shift}, 32'd1);

        // Basic stream, decoder always ready
        instr_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(18'(i));
            issue(18'(i), 1'b1, 1'b1);
            chk("basic_shift", {31'd0, qspi_shift}, 32'd1);
            finish_word(1);
        end
        drain();

        // Back-pressure: shift drops at count 3, held valid is not re-captured
        instr_ready = 1'b0;
        sb.push_back(18'h20); issue(18'h20, 1'b1, 1'b1); finish_word(1);
        sb.push_back(18'h21); issue(18'h21, 1'b1, 1'b0); finish_word(1);
        sb.push_back(18'h22); issue(18'h22, 1'b1, 1'b0);
        chk("bp_shift_low", {31'd0, qspi_shift}, 32'd0);
        finish_word(8);
        chk("bp_shift_still_low", {31'd0, qspi_shift}, 32'd0);
        chk("bp_overflow", {31'd0, overflow}, 32'd0);
        drain();
        chk("bp_shift_back", {31'd0, qspi_shift}, 32'd1);
        sb.push_back(18'h23); issue(18'h23, 1'b1, 1'b1); finish_word(1);
        sb.push_back(18'h24); issue(18'h24, 1'b1, 1'b1); finish_word(1);
        drain();

        // End marker with stalled decoder
        instr_ready = 1'b0;
        sb.push_back(18'h10); issue(18'h10, 1'b1, 1'b1); finish_word(1);
        sb.push_back(18'h11); issue(18'h11, 1'b1, 1'b0); finish_word(1);
        issue(END_W, 1'b1, 1'b0);
        qspi_valid = 1'b0;
        chk("end_frame_done", {31'd0, frame_done}, 32'd1);
        chk("end_rst_n_low", {31'd0, qspi_rst_n}, 32'd0);
        chk("end_shift_low", {31'd0, qspi_shift}, 32'd0);
        pulses = 1;
        low = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pulses += int'(frame_done);
            low++;
            chk("restart_low", {31'd0, qspi_rst_n}, 32'd0);
        end
        chk("end_single_pulse", pulses, 32'd1);
        instr_ready = 1'b1;
        n = 0;
        while (!qspi_rst_n && n < 60) begin
            @(negedge clk);
            n++;
            if (!qspi_rst_n) low++;
        end
        chk("restart_release", {31'd0, qspi_rst_n}, 32'd1);
        chk("restart_min_len", {31'd0, low >= 10}, 32'd1);
        chk("end_sb_empty", sb.size(), 32'd0);
        chk("end_fifo_empty", {31'd0, instr_valid}, 32'd0);

        // Disable mid-stream with two words buffered
        instr_ready = 1'b0;
        sb.push_back(18'h30); issue(18'h30, 1'b1, 1'b1); finish_word(1);
        sb.push_back(18'h31); issue(18'h31, 1'b1, 1'b0); finish_word(1);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("dis_rst_n", {31'd0, qspi_rst_n}, 32'd0);
        sb.delete();
        enable = 1'b1;
        @(negedge clk);
        chk("reen_rst_n", {31'd0, qspi_rst_n}, 32'd1);
        instr_ready = 1'b1;
        sb.push_back(18'h32); issue(18'h32, 1'b1, 1'b1); finish_word(1);
        drain();

        // Forced overflow: reader ignores shift, no pops
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back(18'h40 + 18'(i));
            issue(18'h40 + 18'(i), 1'b0, 1'b0);
            if (i == 3) chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
            finish_word(1);
        end
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_valid", {31'd0, instr_valid}, 32'd1);
        drain();
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Asynchronous reset between clock edges
        instr_ready = 1'b0;
        sb.push_back(18'h50); issue(18'h50, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_qspi_rst_n", {31'd0, qspi_rst_n}, 32'd0);
        chk("arst_shift", {31'd0, qspi_shift}, 32'd0);
        chk("arst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_instr_out", {14'd0, instr_out}, 32'd0);
        chk("arst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("arst_overflow", {31'd0, overflow}, 32'd0);
        qspi_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
